// File: rtl/mux_dff.sv
// Registered 2:1 data selector: sel picks d0 or d1, captured into q on each rising clk.
// rst is asynchronous and active-low; q is forced to RESET_VAL while rst is low.
module mux_dff #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sel,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] d_next;

  // An unknown sel falls through to the default branch, so d0 wins and no X reaches q.
  always_comb begin
    d_next = d0;
    case (sel)
      1'b1:    d_next = d1;
      default: d_next = d0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else begin
      q <= d_next;
    end
  end

endmodule

// File: tb/tb_mux_dff.sv
// Directed bench for mux_dff: a 1-bit instance plus an 8-bit instance with a non-zero reset value.
module tb_mux_dff;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic [0:0] d0;
  logic [0:0] d1;
  logic [0:0] q;
  logic [7:0] wd0;
  logic [7:0] wd1;
  logic [7:0] wq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_dff #(.WIDTH(1), .RESET_VAL(1'b0)) dut (
    .clk(clk), .rst(rst), .d0(d0), .d1(d1), .sel(sel), .q(q)
  );

  mux_dff #(.WIDTH(8), .RESET_VAL(8'hA5)) dut_w (
    .clk(clk), .rst(rst), .d0(wd0), .d1(wd1), .sel(sel), .q(wq)
  );

  // Advance n rising edges and land 2 time units after the last one (drive/sample point).
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 1'b0; d0 = 1'b1; d1 = 1'b1; wd0 = 8'h3C; wd1 = 8'hFF;
    tick(1);
    checks++;
    if (q !== 1'b1) begin errors++; $display("FAIL reset_preload q=%b expected=%b", q, 1'b1); end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (q !== 1'b0) begin errors++; $display("FAIL reset_immediate q=%b expected=%b", q, 1'b0); end
    checks++;
    if (wq !== 8'hA5) begin errors++; $display("FAIL reset_immediate_w wq=%h expected=%h", wq, 8'hA5); end
    sel = 1'($urandom_range(0, 1));
    tick(2);
    checks++;
    if (q !== 1'b0) begin errors++; $display("FAIL reset_hold q=%b expected=%b", q, 1'b0); end
    checks++;
    if (wq !== 8'hA5) begin errors++; $display("FAIL reset_hold_w wq=%h expected=%h", wq, 8'hA5); end
  endtask

  task automatic test_load_d0();
    rst = 1'b1; sel = 1'b0; d0 = 1'b1; d1 = 1'b0; wd0 = 8'h5A; wd1 = 8'hC3;
    tick(2);
    checks++;
    if (q !== 1'b1) begin errors++; $display("FAIL load_d0 q=%b expected=%b", q, 1'b1); end
    checks++;
    if (wq !== 8'h5A) begin errors++; $display("FAIL load_d0_w wq=%h expected=%h", wq, 8'h5A); end
  endtask

  task automatic test_load_d1();
    sel = 1'b1; d0 = 1'b1; d1 = 1'b0; wd0 = 8'h5A; wd1 = 8'hC3;
    tick(2);
    checks++;
    if (q !== 1'b0) begin errors++; $display("FAIL load_d1 q=%b expected=%b", q, 1'b0); end
    checks++;
    if (wq !== 8'hC3) begin errors++; $display("FAIL load_d1_w wq=%h expected=%h", wq, 8'hC3); end
  endtask

  task automatic test_d0_then_d1();
    sel = 1'b0; d0 = 1'b0; d1 = 1'b1; wd0 = 8'h11; wd1 = 8'hEE;
    tick(1);
    checks++;
    if (q !== 1'b0) begin errors++; $display("FAIL d0_then_d1_first q=%b expected=%b", q, 1'b0); end
    checks++;
    if (wq !== 8'h11) begin errors++; $display("FAIL d0_then_d1_first_w wq=%h expected=%h", wq, 8'h11); end
    sel = 1'b1;
    tick(1);
    checks++;
    if (q !== 1'b1) begin errors++; $display("FAIL d0_then_d1_second q=%b expected=%b", q, 1'b1); end
    checks++;
    if (wq !== 8'hEE) begin errors++; $display("FAIL d0_then_d1_second_w wq=%h expected=%h", wq, 8'hEE); end
  endtask

  task automatic test_async_reset();
    sel = 1'b0; d0 = 1'b1; d1 = 1'b0; wd0 = 8'h96; wd1 = 8'h00;
    tick(1);
    checks++;
    if (q !== 1'b1) begin errors++; $display("FAIL async_preload q=%b expected=%b", q, 1'b1); end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (q !== 1'b0) begin errors++; $display("FAIL async_midcycle q=%b expected=%b", q, 1'b0); end
    checks++;
    if (wq !== 8'hA5) begin errors++; $display("FAIL async_midcycle_w wq=%h expected=%h", wq, 8'hA5); end
    tick(2);
    checks++;
    if (q !== 1'b0) begin errors++; $display("FAIL async_hold q=%b expected=%b", q, 1'b0); end
    rst = 1'b1; sel = 1'b1; d1 = 1'b1; wd1 = 8'h77;
    #2;
    checks++;
    if (wq !== 8'hA5) begin errors++; $display("FAIL async_release_no_clock wq=%h expected=%h", wq, 8'hA5); end
    @(posedge clk);
    #2;
    checks++;
    if (q !== 1'b1) begin errors++; $display("FAIL async_release_first_edge q=%b expected=%b", q, 1'b1); end
    checks++;
    if (wq !== 8'h77) begin errors++; $display("FAIL async_release_first_edge_w wq=%h expected=%h", wq, 8'h77); end
  endtask

  task automatic test_sel_x();
    sel = 1'bx; d0 = 1'b1; d1 = 1'b0; wd0 = 8'h42; wd1 = 8'h24;
    tick(1);
    checks++;
    if (q !== 1'b1) begin errors++; $display("FAIL sel_x q=%b expected=%b", q, 1'b1); end
    checks++;
    if (wq !== 8'h42) begin errors++; $display("FAIL sel_x_w wq=%h expected=%h", wq, 8'h42); end
  endtask

  // New vector every cycle; between edges q must still show the previous capture.
  task automatic test_back_to_back();
    logic       v_sel [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] v_d0  [5] = '{8'h01, 8'h80, 8'hFE, 8'h3F, 8'h00};
    logic [7:0] v_d1  [5] = '{8'hF0, 8'h0F, 8'h55, 8'hAA, 8'hC9};
    logic [7:0] v_exp [5] = '{8'h01, 8'h0F, 8'h55, 8'h3F, 8'hC9};
    logic [7:0] prev;
    prev = wq;
    for (int i = 0; i < 5; i++) begin
      sel = v_sel[i]; wd0 = v_d0[i]; wd1 = v_d1[i];
      d0 = v_d0[i][0:0]; d1 = v_d1[i][0:0];
      #1;
      checks++;
      if (wq !== prev) begin errors++; $display("FAIL b2b_hold[%0d] wq=%h expected=%h", i, wq, prev); end
      tick(1);
      checks++;
      if (wq !== v_exp[i]) begin errors++; $display("FAIL b2b_w[%0d] wq=%h expected=%h", i, wq, v_exp[i]); end
      checks++;
      if (q !== v_exp[i][0:0]) begin errors++; $display("FAIL b2b[%0d] q=%b expected=%b", i, q, v_exp[i][0:0]); end
      prev = v_exp[i];
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; d0 = 1'b0; d1 = 1'b0; wd0 = 8'h00; wd1 = 8'h00;
    test_reset();
    test_load_d0();
    test_load_d1();
    test_d0_then_d1();
    test_async_reset();
    test_sel_x();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_dff.md
Name: mux_dff

Overview:
- Registered 2:1 data selector: picks one of two data inputs via `sel` and captures it in a flip-flop on the rising clock edge.
- Leaf storage element used behind the dff_if interface bundle.
- The design side connects through the DUV modport: inputs d0, d1, sel, rst, clk; output q.
- The test side drives and samples through the interface clocking block.

Parameters:
- WIDTH, 1, bit width of d0, d1 and q.
- RESET_VAL, 0 (WIDTH bits), value loaded into q while reset is asserted.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; q forced to RESET_VAL while low.
- d0  input  WIDTH  data input selected when sel=0.
- d1  input  WIDTH  data input selected when sel=1.
- sel  input  1  select: 0 -> d0, 1 -> d1.
- q  output  WIDTH  registered output.

Behaviour:
- Select path is combinational: `d_next` = d0 when sel=0, d1 when sel=1.
- sel = X or Z selects d0 (default branch); no X propagation from sel.
- Register: on each posedge clk with rst=1, q <= d_next.
- Latency: 1 clock from sampled inputs to q.
- Asynchronous reset:
  - On the falling edge of rst, q goes to RESET_VAL immediately, with no clock required.
  - q holds RESET_VAL for as long as rst=0, regardless of clk, sel, d0 and d1.
- Reset release: the first capture happens on the first posedge clk at which rst is sampled 1. There is no extra recovery cycle.
- Reset mid-operation: asserting rst between clock edges clears q at once. Previously loaded data is lost.
- Simultaneous rst deassert and posedge clk: treat as reset still active; q stays RESET_VAL for that edge.
- Input changes between clock edges do not affect q until the next rising edge. q is glitch-free between edges.
- Power-up value of q before any reset is undefined. Benches must apply reset first.
- Interface timing contract:
  - Test side drives outputs thold=2 time units after posedge clk.
  - Test side samples q tsetup=4 time units before posedge clk.
  - The DUT must meet both with zero-delay RTL.
- No internal state other than q. No handshakes. No enables: q updates on every non-reset clock edge.

Test Plan:
- Reset: rst=0, sel=random, d0=1, d1=1, hold 2 clocks -> q=0 (checked 2 clocks after drive), and q=0 immediately after the rst falling edge.
- Load d0=1: rst=1, sel=0, d0=1, d1=0, 2 clocks -> q=1.
- Load d1=0: rst=1, sel=1, d0=1, d1=0, 2 clocks -> q=0.
- Load d0=0 then d1=1:
  - First: sel=0, d0=0, d1=1 -> q=0.
  - Then: sel=1, d0=0, d1=1 -> q=1.
- Async reset mid-operation: q=1, drop rst to 0 halfway between edges -> q=0 before the next posedge. Hold rst=0 two clocks -> q stays 0. Raise rst with sel=1, d1=1 -> q=1 one clock later.
- sel=X with d0=1, d1=0 -> q=1 after one clock (d0 selected).
